// File: rtl/microgreen_feature_packer.sv
// Averages four sensor channels, quantizes each mean to 4 bits and hands the packed word to the BNN classifier.
// Optional build macro MICROGREEN_FEATURE_ROUND_EN selects round-to-nearest (saturating) instead of truncation.

module microgreen_feature_lane #(
    parameter int SAMPLE_BITS = 8,
    parameter int AVG_LOG2    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_inc,
    input  logic [SAMPLE_BITS-1:0] i_data,
    output logic                   o_full,
    output logic [3:0]             o_q
);
    localparam int AW = SAMPLE_BITS + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int NS = 1 << AVG_LOG2;
    localparam int SH = AVG_LOG2 + SAMPLE_BITS - 4;

    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_clr) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_inc && !r_full) begin
            r_acc  <= r_acc + AW'(i_data);
            r_cnt  <= r_cnt + 1'b1;
            r_full <= (r_cnt == CW'(NS - 1));
        end
    end

    assign o_full = r_full;

`ifdef MICROGREEN_FEATURE_ROUND_EN
    // Extra adder bit keeps the carry so a full-scale mean saturates instead of wrapping to 0.
    localparam logic [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (SH - 1);
    logic [AW:0] w_sum;
    logic [4:0]  w_rq;
    assign w_sum = {1'b0, r_acc} + HALF;
    assign w_rq  = 5'(w_sum >> SH);
    assign o_q   = w_rq[4] ? 4'hF : w_rq[3:0];
`else
    assign o_q = 4'(r_acc >> SH);
`endif
endmodule

module microgreen_feature_packer #(
    parameter int SAMPLE_BITS = 8,
    parameter int AVG_LOG2    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [1:0]             s_channel,
    input  logic [SAMPLE_BITS-1:0] s_data,
    output logic                   f_valid,
    input  logic                   f_ready,
    output logic [15:0]            f_features,
    output logic [7:0]             frame_cnt,
    output logic                   busy
);
    typedef enum logic [1:0] {COLLECT, PACK, OUTPUT} state_t;

    state_t          r_state, w_next;
    logic            r_f_valid;
    logic [15:0]     r_features;
    logic [7:0]      r_frame_cnt;
    logic [3:0]      w_full;
    logic [3:0][3:0] w_q;
    logic            w_accept;
    logic            w_hs;

    // Only input-to-output path: ready depends on the requested channel.
    assign s_ready  = (r_state == COLLECT) && !w_full[s_channel];
    assign w_accept = s_valid && s_ready;
    assign w_hs     = r_f_valid && f_ready;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        microgreen_feature_lane #(
            .SAMPLE_BITS(SAMPLE_BITS),
            .AVG_LOG2   (AVG_LOG2)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_hs),
            .i_inc (w_accept && (s_channel == 2'(g))),
            .i_data(s_data),
            .o_full(w_full[g]),
            .o_q   (w_q[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= COLLECT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            COLLECT: if (&w_full) w_next = PACK;
            PACK:    w_next = OUTPUT;
            OUTPUT:  if (f_ready) w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_valid   <= 1'b0;
            r_features  <= '0;
            r_frame_cnt <= '0;
        end else if (r_state == PACK) begin
            r_f_valid  <= 1'b1;
            r_features <= {w_q[3], w_q[2], w_q[1], w_q[0]};
        end else if (w_hs) begin
            r_f_valid   <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign f_valid    = r_f_valid;
    assign f_features = r_features;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = (r_state != COLLECT);
endmodule
